id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 64-bit RISC-V pipeline. It registers the decode-stage control bundle (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp) together with the operands, immediate and register addresses for the execute stage. It also contains load-use hazard detection: it stalls PC and IF/ID and inserts a bubble. On a taken branch it flushes the instruction in decode. A saturating counter records every bubble it injects.

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit RISC-V core, with load-use hazard
// detection, branch-flush bubble insertion and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_memto_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [3:0]        id_funct,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_mem_read,
  output logic              ex_memto_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [3:0]        ex_funct,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              mem_read;
    logic              memto_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [3:0]        funct;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs2_used_c;
  logic             hazard_c;
  logic             bubble_c;

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    rs2_used_c = ~id_alu_src | id_mem_write;
    hazard_c   = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                 ((ex_q.rd == id_rs1) | (rs2_used_c & (ex_q.rd == id_rs2)));
    bubble_c   = flush | hazard_c;
  end

  assign stall = hazard_c & ~flush;

  // A bubble zeroes the whole bundle; otherwise decode is captured, with
  // control gated by valid so a don't-care MemtoReg never reaches EX.
  always_comb begin
    ex_d  = '0;
    cnt_d = cnt_q;
    if (bubble_c) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid     = id_valid;
      ex_d.branch    = id_valid & id_branch;
      ex_d.mem_read  = id_valid & id_mem_read;
      ex_d.memto_reg = id_valid & id_reg_write & id_memto_reg;
      ex_d.mem_write = id_valid & id_mem_write;
      ex_d.alu_src   = id_valid & id_alu_src;
      ex_d.reg_write = id_valid & id_reg_write;
      ex_d.alu_op    = id_valid ? id_alu_op : 2'b00;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.funct     = id_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_branch    = ex_q.branch;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_memto_reg = ex_q.memto_reg;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_alu_src   = ex_q.alu_src;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_funct     = ex_q.funct;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table plus randomized traffic,
// all checked against a reference model of the ID/EX register and hazard rules.
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              mem_read;
    logic              memto_reg;
    logic              mem_write;
    logic              alu_src;
    logic              reg_write;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [3:0]        funct;
  } bundle_t;

  typedef struct {
    bundle_t in;
    bit      rst;
    bit      fl;
    bit      e_stall;
    bit      e_valid;
    int      e_cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset, flush, stall;
  logic              id_valid, id_branch, id_mem_read, id_memto_reg, id_mem_write;
  logic              id_alu_src, id_reg_write;
  logic [1:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]        id_funct;
  logic              ex_valid, ex_branch, ex_mem_read, ex_memto_reg, ex_mem_write;
  logic              ex_alu_src, ex_reg_write;
  logic [1:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_W-1:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]        ex_funct;
  logic [CNT_W-1:0]  bubble_count;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_memto_reg(id_memto_reg), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct(id_funct), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_memto_reg(ex_memto_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  bundle_t m_ex     = '0;
  int      m_cnt    = 0;
  bit      m_known  = 1'b0;
  vec_t    vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A dependent instruction in decode must wait one cycle behind a load in EX.
  function automatic bit m_hazard(input bundle_t i);
    bit uses_rs2;
    uses_rs2 = !i.alu_src || i.mem_write;
    return i.valid && m_ex.valid && m_ex.mem_read && (m_ex.rd != 0) &&
           ((m_ex.rd == i.rs1) || (uses_rs2 && (m_ex.rd == i.rs2)));
  endfunction

  function automatic bundle_t rnd();
    bundle_t b;
    b.valid     = ($urandom_range(0, 9) < 8);
    b.branch    = 1'($urandom);
    b.mem_read  = 1'($urandom);
    b.memto_reg = 1'($urandom);
    b.mem_write = 1'($urandom);
    b.alu_src   = 1'($urandom);
    b.reg_write = 1'($urandom);
    b.alu_op    = 2'($urandom);
    b.pc        = {$urandom, $urandom};
    b.rs1_data  = {$urandom, $urandom};
    b.rs2_data  = {$urandom, $urandom};
    b.imm       = {$urandom, $urandom};
    b.rs1       = REG_W'($urandom_range(0, 3));
    b.rs2       = REG_W'($urandom_range(0, 3));
    b.rd        = REG_W'($urandom_range(0, 3));
    b.funct     = 4'($urandom);
    return b;
  endfunction

  function automatic bundle_t mk(input bit v, input bit mr, input bit mw, input bit asrc,
                                 input bit rw, input logic [1:0] aop, input int rs1,
                                 input int rs2, input int rd, input logic [63:0] pc);
    bundle_t b;
    b = rnd();
    b.valid = v; b.branch = 1'b0; b.mem_read = mr; b.memto_reg = mr;
    b.mem_write = mw; b.alu_src = asrc; b.reg_write = rw; b.alu_op = aop;
    b.rs1 = REG_W'(rs1); b.rs2 = REG_W'(rs2); b.rd = REG_W'(rd); b.pc = pc;
    return b;
  endfunction

  function automatic void add_vec(input bundle_t b, input bit rst, input bit fl,
                                  input bit es, input bit ev, input int ec);
    vec_t v;
    v.in = b; v.rst = rst; v.fl = fl; v.e_stall = es; v.e_valid = ev; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic drive(input bundle_t b);
    id_valid = b.valid; id_branch = b.branch; id_mem_read = b.mem_read;
    id_memto_reg = b.memto_reg; id_mem_write = b.mem_write; id_alu_src = b.alu_src;
    id_reg_write = b.reg_write; id_alu_op = b.alu_op; id_pc = b.pc;
    id_rs1_data = b.rs1_data; id_rs2_data = b.rs2_data; id_imm = b.imm;
    id_rs1 = b.rs1; id_rs2 = b.rs2; id_rd = b.rd; id_funct = b.funct;
  endtask

  // One clock: check combinational stall, advance model, check registered outputs.
  task automatic step(input bundle_t b, input bit rst, input bit fl, input bit has_exp,
                      input bit es, input bit ev, input int ec);
    bit haz;
    drive(b);
    reset = rst;
    flush = fl;
    #1;
    haz = m_hazard(b);
    if (m_known) chk("stall", 256'(stall), 256'(haz && !fl));
    if (has_exp && m_known) chk("tbl_stall", 256'(stall), 256'(es));
    @(posedge clk);
    if (rst) begin
      m_ex = '0; m_cnt = 0; m_known = 1'b1;
    end else if (fl || haz) begin
      m_ex = '0;
      m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
    end else begin
      m_ex = b;
      if (!b.valid) begin
        m_ex.branch = 0; m_ex.mem_read = 0; m_ex.mem_write = 0;
        m_ex.alu_src = 0; m_ex.reg_write = 0; m_ex.alu_op = 2'b00;
      end
      m_ex.memto_reg = b.valid && b.reg_write && b.memto_reg;
    end
    #1;
    if (m_known) begin
      chk("ex_valid", 256'(ex_valid), 256'(m_ex.valid));
      chk("ctrl", 256'({ex_branch, ex_mem_read, ex_memto_reg, ex_mem_write, ex_alu_src,
                        ex_reg_write, ex_alu_op}),
          256'({m_ex.branch, m_ex.mem_read, m_ex.memto_reg, m_ex.mem_write,
                m_ex.alu_src, m_ex.reg_write, m_ex.alu_op}));
      chk("data", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm},
          {m_ex.pc, m_ex.rs1_data, m_ex.rs2_data, m_ex.imm});
      chk("addr", 256'({ex_rs1, ex_rs2, ex_rd, ex_funct}),
          256'({m_ex.rs1, m_ex.rs2, m_ex.rd, m_ex.funct}));
      chk("bubble_count", 256'(bubble_count), 256'(m_cnt));
    end
    if (has_exp) begin
      chk("tbl_valid", 256'(ex_valid), 256'(ev));
      chk("tbl_cnt", 256'(bubble_count), 256'(ec));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bundle_t ld6, use6, idle;
    ld6  = mk(1, 1, 0, 1, 1, 2'b00, 3, 0, 6, 64'h100);
    use6 = mk(1, 0, 0, 0, 1, 2'b10, 6, 4, 7, 64'h104);
    idle = mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 64'h0);
    // Reset held two cycles, then pass-through and load-use scenarios.
    add_vec(rnd(), 1, 0, 0, 0, 0);
    add_vec(rnd(), 1, 0, 0, 0, 0);
    add_vec(mk(1, 0, 0, 0, 1, 2'b10, 3, 4, 5, 64'h40), 0, 0, 0, 1, 0);
    add_vec(ld6, 0, 0, 0, 1, 0);
    add_vec(use6, 0, 0, 1, 0, 1);
    add_vec(use6, 0, 0, 0, 1, 1);
    add_vec(mk(1, 1, 0, 1, 1, 2'b00, 1, 0, 0, 64'h108), 0, 0, 0, 1, 1);
    add_vec(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 2, 64'h10c), 0, 0, 0, 1, 1);
    add_vec(ld6, 0, 0, 0, 1, 1);
    add_vec(mk(1, 0, 0, 1, 1, 2'b00, 1, 6, 2, 64'h110), 0, 0, 0, 1, 1);
    add_vec(ld6, 0, 0, 0, 1, 1);
    add_vec(mk(1, 0, 1, 1, 0, 2'b00, 1, 6, 0, 64'h114), 0, 0, 1, 0, 2);
    add_vec(mk(1, 0, 1, 1, 0, 2'b00, 1, 6, 0, 64'h114), 0, 0, 0, 1, 2);
    // Flush coinciding with a hazard: one bubble, no stall.
    add_vec(ld6, 0, 0, 0, 1, 2);
    add_vec(use6, 0, 1, 0, 0, 3);
    add_vec(use6, 0, 0, 0, 1, 3);
    // Drive the 3-bit counter into saturation.
    for (int i = 4; i <= 9; i++) add_vec(rnd(), 0, 1, 0, 0, (i > CNT_SAT) ? CNT_SAT : i);
    add_vec(idle, 0, 0, 0, 0, CNT_SAT);
    // Reset during a stall wins.
    add_vec(ld6, 0, 0, 0, 1, CNT_SAT);
    add_vec(use6, 1, 0, 1, 0, 0);
    add_vec(use6, 0, 0, 0, 1, 0);

    foreach (vecs[i])
      step(vecs[i].in, vecs[i].rst, vecs[i].fl, 1'b1,
           vecs[i].e_stall, vecs[i].e_valid, vecs[i].e_cnt);

    for (int i = 0; i < 400; i++) begin
      bundle_t b;
      b = rnd();
      step(b, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), 1'b0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
